// File: rtl/wb_periph_hub_pkg.sv
// Shared types and constants for the Wishbone peripheral hub.
package wb_periph_hub_pkg;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  localparam logic [3:0] CSR_SLOT = 4'hF;

  localparam logic [1:0] CSR_IRQ_RAW  = 2'd0;
  localparam logic [1:0] CSR_IRQ_MASK = 2'd1;
  localparam logic [1:0] CSR_IRQ_PEND = 2'd2;
  localparam logic [1:0] CSR_ERR_CNT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } hub_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_periph_hub_csr.sv
// Internal CSR slot: IRQ raw/mask/pending, saturating error counter, read mux.
module wb_periph_hub_csr
  import wb_periph_hub_pkg::*;
#(
  parameter int unsigned NUM_PERIPH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PERIPH-1:0] p_irq,
  input  logic                  wr_en,
  input  logic [1:0]            offset,
  input  logic [NUM_PERIPH-1:0] wr_data,
  input  logic                  err_inc,
  output logic [31:0]           rd_data_c,
  output logic [1:0]            irq_out
);

  logic [NUM_PERIPH-1:0] mask_q;
  logic [NUM_PERIPH-1:0] pend_c;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d;
  logic                  clr_c;

  assign pend_c = p_irq & mask_q;
  assign clr_c  = wr_en && (offset == CSR_ERR_CNT);

  // A clear and an error in the same cycle leave exactly one error recorded.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_c) begin
      err_cnt_d = err_inc ? ERR_CNT_W'(1) : '0;
    end else if (err_inc && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_comb begin
    rd_data_c = '0;
    case (offset)
      CSR_IRQ_RAW:  rd_data_c = 32'(p_irq);
      CSR_IRQ_MASK: rd_data_c = 32'(mask_q);
      CSR_IRQ_PEND: rd_data_c = 32'(pend_c);
      CSR_ERR_CNT:  rd_data_c = 32'(err_cnt_q);
      default:      rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q    <= '0;
      err_cnt_q <= '0;
      irq_out   <= '0;
    end else begin
      if (wr_en && (offset == CSR_IRQ_MASK)) begin
        mask_q <= wr_data;
      end
      err_cnt_q <= err_cnt_d;
      irq_out   <= {err_cnt_q != '0, |pend_c};
    end
  end

endmodule

// File: rtl/wb_periph_hub.sv
// Registered Wishbone fan-out to NUM_PERIPH slots with watchdog, error
// responses for unmapped slots and an internal CSR slot at index 15.
module wb_periph_hub
  import wb_periph_hub_pkg::*;
#(
  parameter int unsigned NUM_PERIPH = 4,
  parameter int unsigned SEL_LSB    = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [2:0]                 user_irq,
  output logic [NUM_PERIPH-1:0]      p_cyc_o,
  output logic [NUM_PERIPH-1:0]      p_stb_o,
  output logic                       p_we_o,
  output logic [3:0]                 p_sel_o,
  output logic [31:0]                p_adr_o,
  output logic [31:0]                p_dat_o,
  input  logic [NUM_PERIPH-1:0]      p_ack_i,
  input  logic [32*NUM_PERIPH-1:0]   p_dat_i,
  input  logic [NUM_PERIPH-1:0]      p_irq_i
);

  localparam int unsigned WD_W = 8;

  hub_state_e state_q, state_d;

  wb_req_t                req_q;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [NUM_PERIPH-1:0]  slot_oh_c;
  logic [NUM_PERIPH-1:0]  p_oh_d;
  logic [31:0]            periph_rd_c;
  logic [31:0]            resp_d;
  logic [31:0]            csr_rd_data_c;
  logic [3:0]             idx_c;
  logic [1:0]             csr_irq;
  logic                   req_c, is_periph_c, is_csr_c;
  logic                   periph_ack_c, wd_done_c;
  logic                   cap_c, ack_d, err_inc_c, csr_we_c;

  assign idx_c        = wbs_adr_i[SEL_LSB +: 4];
  assign req_c        = wbs_cyc_i && wbs_stb_i;
  assign is_periph_c  = ({1'b0, idx_c} < 5'(NUM_PERIPH));
  assign is_csr_c     = (idx_c == CSR_SLOT);
  assign periph_ack_c = |(p_ack_i & p_cyc_o);
  assign wd_done_c    = (wd_q == WD_W'(TIMEOUT));

  // Slot decode and read-data select; p_cyc_o is one-hot while waiting.
  always_comb begin
    slot_oh_c   = '0;
    periph_rd_c = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      slot_oh_c[k] = (idx_c == 4'(k));
      if (p_cyc_o[k]) begin
        periph_rd_c = periph_rd_c | p_dat_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An abandoned cycle is dropped before considering ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          state_d = is_periph_c ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (periph_ack_c || wd_done_c) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cap_c     = 1'b0;
    p_oh_d    = p_cyc_o;
    resp_d    = wbs_dat_o;
    err_inc_c = 1'b0;
    csr_we_c  = 1'b0;
    wd_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          cap_c = 1'b1;
          if (is_periph_c) begin
            p_oh_d = slot_oh_c;
          end else if (is_csr_c) begin
            resp_d   = csr_rd_data_c;
            csr_we_c = wbs_we_i;
          end else begin
            resp_d    = ERR_DATA;
            err_inc_c = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (!wbs_cyc_i) begin
          p_oh_d = '0;
        end else if (periph_ack_c) begin
          p_oh_d = '0;
          resp_d = periph_rd_c;
        end else if (wd_done_c) begin
          p_oh_d    = '0;
          resp_d    = ERR_DATA;
          err_inc_c = 1'b1;
        end
      end
      ST_RESP: p_oh_d = '0;
      default: p_oh_d = '0;
    endcase
    ack_d = (state_d == ST_RESP);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      p_cyc_o   <= '0;
      p_stb_o   <= '0;
      wd_q      <= '0;
      req_q     <= '0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_dat_o <= resp_d;
      p_cyc_o   <= p_oh_d;
      p_stb_o   <= p_oh_d;
      wd_q      <= wd_d;
      if (cap_c) begin
        req_q <= '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
      end
    end
  end

  assign p_we_o  = req_q.we;
  assign p_sel_o = req_q.sel;
  assign p_adr_o = req_q.adr;
  assign p_dat_o = req_q.dat;

  wb_periph_hub_csr #(
    .NUM_PERIPH(NUM_PERIPH)
  ) u_csr (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .p_irq     (p_irq_i),
    .wr_en     (csr_we_c),
    .offset    (wbs_adr_i[3:2]),
    .wr_data   (wbs_dat_i[NUM_PERIPH-1:0]),
    .err_inc   (err_inc_c),
    .rd_data_c (csr_rd_data_c),
    .irq_out   (csr_irq)
  );

  assign user_irq = {1'b0, csr_irq};

endmodule
